// File: rtl/cpr_pkg.sv
`default_nettype none
// cpr_pkg: sizing helpers and the lane record for the N-way s-coordinate selector.
package cpr_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Two guard bits keep the three-term sum of the absolute coordinate from wrapping.
  function automatic int abs_w(input int fdssi_w, input int fd_shift, input int ssi_w,
                               input int ss_shift, input int s_w);
    int m;
    m = fdssi_w + fd_shift;
    if (ssi_w + ss_shift > m) m = ssi_w + ss_shift;
    if (s_w > m) m = s_w;
    return m + 2;
  endfunction

  // Lane record at the default configuration; the modules build the same layout
  // from their own parameters.
  typedef struct packed {
    logic        valid;
    logic        wt;
    logic        mode;
    logic [1:0]  idx;
    logic [21:0] abs;
    logic [11:0] fdssi;
    logic [7:0]  ssi;
    logic [1:0]  s;
    logic [27:0] fdsti;
  } lane_rec_t;

endpackage
`default_nettype wire

// File: rtl/cpr_node.sv
`default_nettype none
// cpr_node: combinational 2:1 node; input a is the lower lane index, ties go to a.
module cpr_node
  import cpr_pkg::*;
#(
  parameter int IDX_W   = 2,
  parameter int ABS_W   = 22,
  parameter int FDSSI_W = 12,
  parameter int SSI_W   = 8,
  parameter int S_W     = 2,
  parameter int FDSTI_W = 28,
  localparam int REC_W  = 3 + IDX_W + ABS_W + FDSSI_W + SSI_W + S_W + FDSTI_W
) (
  input  logic [REC_W-1:0] i_a,
  input  logic [REC_W-1:0] i_b,
  output logic [REC_W-1:0] o_y
);

  // Field order must match the record used in cpr_tree_n.
  typedef struct packed {
    logic               valid;
    logic               wt;
    logic               mode;
    logic [IDX_W-1:0]   idx;
    logic [ABS_W-1:0]   abs;
    logic [FDSSI_W-1:0] fdssi;
    logic [SSI_W-1:0]   ssi;
    logic [S_W-1:0]     s;
    logic [FDSTI_W-1:0] fdsti;
  } rec_t;

  rec_t w_a;
  rec_t w_b;
  rec_t w_y;
  logic w_b_wins;
  logic w_unused;

  assign w_a      = i_a;
  assign w_b      = i_b;
  assign o_y      = w_y;
  assign w_unused = w_b.mode;

  always_comb begin
    w_b_wins = w_a.mode ? (w_b.abs > w_a.abs) : (w_b.abs < w_a.abs);
    w_y      = w_a;
    case ({w_a.valid, w_b.valid})
      2'b11: begin
        w_y       = w_b_wins ? w_b : w_a;
        w_y.valid = 1'b1;
        w_y.wt    = w_a.wt | w_b.wt;
      end
      // A pending sibling makes a lone candidate undecidable.
      2'b01: begin
        w_y       = w_b;
        w_y.valid = ~w_a.wt;
        w_y.wt    = w_a.wt;
      end
      2'b10: begin
        w_y       = w_a;
        w_y.valid = ~w_b.wt;
        w_y.wt    = w_b.wt;
      end
      default: begin
        w_y       = w_a;
        w_y.valid = 1'b0;
        w_y.wt    = w_a.wt | w_b.wt;
      end
    endcase
    w_y.mode = w_a.mode;
  end

endmodule
`default_nettype wire

// File: rtl/cpr_tree_n.sv
`default_nettype none
// cpr_tree_n: pipelined N-way min/max selector on the absolute s coordinate,
// one register stage per tree level, with a single global stall.
module cpr_tree_n
  import cpr_pkg::*;
#(
  parameter int N_LANES  = 4,
  parameter int FDSSI_W  = 12,
  parameter int SSI_W    = 8,
  parameter int S_W      = 2,
  parameter int FDSTI_W  = 28,
  parameter int FD_SHIFT = 8,
  parameter int SS_SHIFT = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_LANES-1:0]           valid,
  input  logic [N_LANES-1:0]           wt,
  input  logic                         mode,
  input  logic [N_LANES*FDSSI_W-1:0]   FDSSI,
  input  logic [N_LANES*SSI_W-1:0]     SSI,
  input  logic [N_LANES*S_W-1:0]       s,
  input  logic [N_LANES*FDSTI_W-1:0]   FDSTI,
  output logic                         in_ready,
  input  logic                         out_ready,
  output logic                         valid_o,
  output logic                         wt_o,
  output logic [FDSSI_W-1:0]           FDSSI_o,
  output logic [SSI_W-1:0]             SSI_o,
  output logic [S_W-1:0]               s_o,
  output logic [FDSTI_W-1:0]           FDSTI_o,
  output logic [clog2(N_LANES)-1:0]    idx_o
);

  localparam int c_l     = clog2(N_LANES);
  localparam int c_np    = 1 << c_l;
  localparam int c_idx_w = c_l;
  localparam int c_abs_w = abs_w(FDSSI_W, FD_SHIFT, SSI_W, SS_SHIFT, S_W);

  typedef struct packed {
    logic               valid;
    logic               wt;
    logic               mode;
    logic [c_idx_w-1:0] idx;
    logic [c_abs_w-1:0] abs;
    logic [FDSSI_W-1:0] fdssi;
    logic [SSI_W-1:0]   ssi;
    logic [S_W-1:0]     s;
    logic [FDSTI_W-1:0] fdsti;
  } rec_t;

  localparam int   c_rec_w   = $bits(rec_t);
  localparam rec_t c_rst_rec = rec_t'({2'b01, {(c_rec_w-2){1'b0}}});

  function automatic rec_t mk_leaf(input logic v, input logic w, input logic m,
                                   input logic [c_idx_w-1:0] ix,
                                   input logic [FDSSI_W-1:0] fd, input logic [SSI_W-1:0] ss,
                                   input logic [S_W-1:0] sv, input logic [FDSTI_W-1:0] ft);
    rec_t r;
    r.valid = v;
    r.wt    = w;
    r.mode  = m;
    r.idx   = ix;
    r.abs   = (c_abs_w'(fd) << FD_SHIFT) + (c_abs_w'(ss) << SS_SHIFT) + c_abs_w'(sv);
    r.fdssi = fd;
    r.ssi   = ss;
    r.s     = sv;
    r.fdsti = ft;
    return r;
  endfunction

  // Heap layout: node j feeds from 2j and 2j+1; indices >= c_np are leaves.
  rec_t w_leaf [c_np];
  rec_t w_node [1:c_np-1];
  rec_t r_node [1:c_np-1];
  logic w_stall;
  logic w_unused;

  for (genvar i = 0; i < c_np; i++) begin : g_leaf
    if (i < N_LANES) begin : g_lane
      assign w_leaf[i] = mk_leaf(valid[i], wt[i], mode, c_idx_w'(i),
                                 FDSSI[i*FDSSI_W +: FDSSI_W], SSI[i*SSI_W +: SSI_W],
                                 s[i*S_W +: S_W], FDSTI[i*FDSTI_W +: FDSTI_W]);
    end else begin : g_pad
      assign w_leaf[i] = mk_leaf(1'b0, 1'b0, mode, c_idx_w'(i),
                                 '0, '0, '0, '0);
    end
  end

  for (genvar j = 1; j < c_np; j++) begin : g_node
    rec_t w_a;
    rec_t w_b;
    if (2*j >= c_np) begin : g_from_leaf
      assign w_a = w_leaf[2*j - c_np];
      assign w_b = w_leaf[2*j + 1 - c_np];
    end else begin : g_from_reg
      assign w_a = r_node[2*j];
      assign w_b = r_node[2*j + 1];
    end
    cpr_node #(
      .IDX_W   (c_idx_w),
      .ABS_W   (c_abs_w),
      .FDSSI_W (FDSSI_W),
      .SSI_W   (SSI_W),
      .S_W     (S_W),
      .FDSTI_W (FDSTI_W)
    ) u_node (
      .i_a (w_a),
      .i_b (w_b),
      .o_y (w_node[j])
    );
  end

  assign w_stall  = r_node[1].valid & ~out_ready;
  assign in_ready = ~w_stall;

  always_ff @(posedge clk) begin
    for (int j = 1; j < c_np; j++) begin
      if (!rst_n) begin
        r_node[j] <= c_rst_rec;
      end else if (!w_stall) begin
        r_node[j] <= w_node[j];
      end
    end
  end

  assign valid_o  = r_node[1].valid;
  assign wt_o     = r_node[1].wt;
  assign idx_o    = r_node[1].idx;
  assign FDSSI_o  = r_node[1].fdssi;
  assign SSI_o    = r_node[1].ssi;
  assign s_o      = r_node[1].s;
  assign FDSTI_o  = r_node[1].fdsti;
  assign w_unused = ^{r_node[1].mode, r_node[1].abs};

endmodule
`default_nettype wire
